// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-cache port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned CNT_W            = 3;
    localparam int unsigned PORT_MEM         = 0;
    localparam int unsigned PORT_LDR         = 1;
    localparam int unsigned READ_LAT_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lat_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin winner select; the port not granted last wins a tie.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win_c
);

    always_comb begin
        win_c = req;
        if (req == 2'b11) begin
            win_c = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dcache_arbiter.sv
// Arbitrates the MEM-stage and loader ports onto a single data-cache interface.
module dcache_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LAT = READ_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] dCacheAddr,
    output logic [DATA_W-1:0] dCacheWriteData,
    output logic              dCacheWriteEn,
    output logic              dCacheReadEn,
    input  logic [DATA_W-1:0] dCacheReadData
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

    arb_state_t        state, state_d;
    lat_req_t          cur, cur_d;
    logic              owner, owner_d;
    logic              last, last_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [1:0]        gnt_d, ack_d;
    logic              err_d;
    logic [DATA_W-1:0] rdata_d;
    logic [ADDR_W-1:0] caddr_d;
    logic [DATA_W-1:0] cwdata_d;
    logic              cwe_d, cre_d;
    logic [1:0]        win_c;
    logic              misaligned_c;

    rr_arbiter2 u_rr (
        .req   (req),
        .last  (last),
        .win_c (win_c)
    );

    assign misaligned_c = (cur.addr[1:0] != 2'b00);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cur             <= '0;
            owner           <= 1'b0;
            last            <= 1'(PORT_LDR);
            cnt             <= '0;
            gnt             <= '0;
            ack             <= '0;
            err             <= 1'b0;
            rdata           <= '0;
            dCacheAddr      <= '0;
            dCacheWriteData <= '0;
            dCacheWriteEn   <= 1'b0;
            dCacheReadEn    <= 1'b0;
        end else begin
            state           <= state_d;
            cur             <= cur_d;
            owner           <= owner_d;
            last            <= last_d;
            cnt             <= cnt_d;
            gnt             <= gnt_d;
            ack             <= ack_d;
            err             <= err_d;
            rdata           <= rdata_d;
            dCacheAddr      <= caddr_d;
            dCacheWriteData <= cwdata_d;
            dCacheWriteEn   <= cwe_d;
            dCacheReadEn    <= cre_d;
        end
    end

    // Next state and next registered outputs; pulses default low, data holds.
    always_comb begin
        state_d  = state;
        cur_d    = cur;
        owner_d  = owner;
        last_d   = last;
        cnt_d    = cnt;
        gnt_d    = '0;
        ack_d    = '0;
        err_d    = 1'b0;
        rdata_d  = rdata;
        caddr_d  = dCacheAddr;
        cwdata_d = dCacheWriteData;
        cwe_d    = 1'b0;
        cre_d    = 1'b0;

        unique case (state)
            IDLE: begin
                if (|req) begin
                    owner_d     = win_c[PORT_LDR];
                    last_d      = win_c[PORT_LDR];
                    cur_d.we    = win_c[PORT_LDR] ? we[PORT_LDR] : we[PORT_MEM];
                    cur_d.addr  = win_c[PORT_LDR] ? addr1 : addr0;
                    cur_d.wdata = win_c[PORT_LDR] ? wdata1 : wdata0;
                    gnt_d       = win_c;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                caddr_d = cur.addr;
                cnt_d   = '0;
                if (misaligned_c) begin
                    state_d = DONE;
                end else if (cur.we) begin
                    cwdata_d = cur.wdata;
                    cwe_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cre_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                ack_d[owner] = 1'b1;
                err_d        = misaligned_c;
                // Read data is valid in this cycle; it becomes visible with ack.
                if (!cur.we && !misaligned_c) begin
                    rdata_d = dCacheReadData;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
